fc_layer_sequencer: RTL and testbench

- Sequences one fully-connected layer built from NEURONS combinational neuron instances. Each instance is a constant-weight Booth multiplier bank feeding an adder tree and a ReLU.
- Collects IN activations from a serial valid/ready stream into a register bank. That bank drives all neuron inputs in parallel.
- Waits a programmable settle interval for the multicycle adder-tree path, then captures all neuron sums at once.
- Requantizes each sum to WIDTH bits and streams the results out serially. The next input frame loads while results drain.

---
 rtl/fc_layer_sequencer.sv | 99 +++++++++
 tb/tb_fc_layer_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_layer_sequencer.sv
// fc_layer_sequencer: serial activation loader, settle/capture timer and requantizing result streamer for one FC layer
module fc_layer_sequencer #(
    parameter int WIDTH   = 8,
    parameter int IN      = 128,
    parameter int NEURONS = 10,
    parameter int SUM_W   = 23,
    parameter int SHIFT   = 7,
    parameter int SETTLE  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         in_valid,
    input  logic                         in_last,
    output logic                         in_ready,
    output logic [IN*WIDTH-1:0]          x_bus,
    input  logic [NEURONS*SUM_W-1:0]     z_bus,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(NEURONS)-1:0]   out_idx,
    output logic                         out_valid,
    output logic                         out_last,
    input  logic                         out_ready,
    output logic                         busy,
    output logic                         err
);
    localparam int IW = $clog2(IN);
    localparam int OW = $clog2(NEURONS);
    localparam int CW = $clog2(SETTLE + 2);
    localparam logic [SUM_W:0] RND  = (SUM_W+1)'((1 << SHIFT) >> 1);
    localparam logic [SUM_W:0] MAXV = (SUM_W+1)'((1 << WIDTH) - 1);

    typedef enum logic {S_FILL, S_WAIT} state_t;

    state_t            state, state_nxt;
    logic [IW-1:0]     idx;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  res [NEURONS];
    logic [OW-1:0]     nidx;
    logic              accept, at_end, capture;

    function automatic logic [WIDTH-1:0] rq(input logic [SUM_W-1:0] z);
        logic [SUM_W:0] r;
        r = {1'b0, z} + RND;
        r = r >> SHIFT;
        return (r > MAXV) ? MAXV[WIDTH-1:0] : r[WIDTH-1:0];
    endfunction

    assign accept  = in_valid & in_ready;
    assign at_end  = idx == IW'(IN - 1);
    assign capture = state == S_WAIT && cnt == '0 && !out_valid;
    assign nidx    = out_idx + 1'b1;

    always_ff @(posedge clk)
        state <= rst ? S_FILL : state_nxt;

    always_comb
        state_nxt = state == S_FILL ? ((accept && at_end) ? S_WAIT : S_FILL)
                                    : (capture ? S_FILL : S_WAIT);

    always_comb begin
        in_ready = !rst && state == S_FILL;
        busy     = idx != '0 || state == S_WAIT || out_valid;
        out_last = out_valid && out_idx == OW'(NEURONS - 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            cnt       <= '0;
            x_bus     <= '0;
            err       <= 1'b0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_data  <= '0;
            for (int n = 0; n < NEURONS; n++) res[n] <= '0;
        end else begin
            err <= 1'b0;
            if (accept) begin
                x_bus[idx*WIDTH +: WIDTH] <= in_data;
                idx <= (at_end || in_last) ? '0 : idx + 1'b1;
                err <= at_end ? !in_last : in_last;
                if (at_end) cnt <= CW'(SETTLE);
            end else if (state == S_WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            // capture waits for an idle output side so undrained results are never overwritten
            if (capture) begin
                for (int n = 0; n < NEURONS; n++) res[n] <= rq(z_bus[n*SUM_W +: SUM_W]);
                out_valid <= 1'b1;
                out_idx   <= '0;
                out_data  <= rq(z_bus[SUM_W-1:0]);
            end else if (out_valid && out_ready) begin
                out_valid <= !out_last;
                out_idx   <= out_last ? '0 : nidx;
                out_data  <= out_last ? res[0] : res[nidx];
            end
        end
    end
endmodule

// File: tb/tb_fc_layer_sequencer.sv
// tb_fc_layer_sequencer: scoreboard bench for fc_layer_sequencer, plus a SETTLE=0 instance for latency
module tb_fc_layer_sequencer;
    localparam int WIDTH = 8, IN = 128, NEURONS = 10, SUM_W = 23, SHIFT = 7;

    logic                       clk = 1'b0, rst = 1'b1;
    logic [WIDTH-1:0]           in_data = '0;
    logic                       in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
    logic [NEURONS*SUM_W-1:0]   z_bus = '0;
    logic                       in_ready, out_valid, out_last, busy, err;
    logic [IN*WIDTH-1:0]        x_bus;
    logic [WIDTH-1:0]           out_data;
    logic [3:0]                 out_idx;
    logic                       in_ready0, out_valid0, out_last0, busy0, err0;
    logic [IN*WIDTH-1:0]        x_bus0;
    logic [WIDTH-1:0]           out_data0;
    logic [3:0]                 out_idx0;

    int checks = 0, fails = 0, cyc = 0;
    int exp_q[$];
    int zv[NEURONS];

    fc_layer_sequencer dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .x_bus(x_bus), .z_bus(z_bus), .out_data(out_data),
        .out_idx(out_idx), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
        .busy(busy), .err(err)
    );

    fc_layer_sequencer #(.SETTLE(0)) dut0 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready0), .x_bus(x_bus0), .z_bus(z_bus), .out_data(out_data0),
        .out_idx(out_idx0), .out_valid(out_valid0), .out_last(out_last0), .out_ready(out_ready),
        .busy(busy0), .err(err0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int model(input int z);
        int q;
        q = (z + (1 << (SHIFT - 1))) / (1 << SHIFT);
        return q > 255 ? 255 : q;
    endfunction

    task automatic load_z(input bit push);
        for (int n = 0; n < NEURONS; n++) begin
            z_bus[n*SUM_W +: SUM_W] = SUM_W'(zv[n]);
            if (push) exp_q.push_back(n * 256 + model(zv[n]));
        end
    endtask

    task automatic send_frame(input int n, input int last_pos, input int base,
                              output int t_acc, output int errs);
        int k;
        errs = 0;
        t_acc = -1;
        for (int i = 0; i < n; i++) begin
            in_data  = WIDTH'(i + base);
            in_last  = (i == last_pos);
            in_valid = 1'b1;
            k = 0;
            while (!in_ready && k < 1000) begin
                @(negedge clk);
                k++;
            end
            if (k >= 1000) begin
                checks++; fails++;
                $display("FAIL send_timeout: element %0d never accepted", i);
                break;
            end
            t_acc = cyc;
            @(negedge clk);
            if (err) errs++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain(input int n, input int stall_idx, input int stall_n,
                         output int tfirst, output int tlast);
        int beats, stalled, k, e;
        logic [WIDTH-1:0] hd;
        beats = 0; stalled = 0; k = 0; tfirst = -1; tlast = -1; hd = '0;
        while (beats < n && k < 2000) begin
            @(negedge clk);
            k++;
            if (out_valid) begin
                if (tfirst < 0) tfirst = cyc;
                if (int'(out_idx) == stall_idx && stalled < stall_n) begin
                    if (stalled == 0) hd = out_data;
                    else begin
                        checks++;
                        if (out_data !== hd || out_idx !== 4'(stall_idx)) begin
                            fails++;
                            $display("FAIL hold: got idx %0d data %0d, expected idx %0d data %0d", out_idx, out_data, stall_idx, hd);
                        end
                    end
                    out_ready = 1'b0;
                    stalled++;
                end else begin
                    out_ready = 1'b1;
                    checks++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL extra_beat: got idx %0d data %0d, expected no beat", out_idx, out_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (out_idx !== 4'(e / 256) || out_data !== 8'(e % 256) || out_last !== (e / 256 == NEURONS - 1)) begin
                            fails++;
                            $display("FAIL beat: got idx %0d data %0d last %0b, expected idx %0d data %0d last %0b",
                                     out_idx, out_data, out_last, e / 256, e % 256, e / 256 == NEURONS - 1);
                        end
                    end
                    beats++;
                    tlast = cyc;
                end
            end
        end
        if (beats < n) begin
            checks++; fails++;
            $display("FAIL drain_timeout: got %0d beats, expected %0d", beats, n);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0 ||
            out_idx !== '0 || out_data !== '0 || out_last !== 1'b0 || x_bus !== '0) begin
            fails++;
            $display("FAIL reset_state: got rdy %b vld %b busy %b err %b idx %0d data %0d last %b xzero %b, expected all 0",
                     in_ready, out_valid, busy, err, out_idx, out_data, out_last, x_bus == '0);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL post_reset: got in_ready %b busy %b, expected 1 0", in_ready, busy);
        end
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_settle0();
        int t, e, t0, tm, tf, tl;
        t0 = -1; tm = -1;
        out_ready = 1'b0;
        for (int n = 0; n < NEURONS; n++) zv[n] = n * 192;
        load_z(1);
        send_frame(IN, IN - 1, 0, t, e);
        for (int k = 0; k < 20 && (t0 < 0 || tm < 0); k++) begin
            @(negedge clk);
            if (out_valid0 && t0 < 0) t0 = cyc;
            if (out_valid && tm < 0) tm = cyc;
        end
        checks++;
        if (t0 !== t + 2) begin
            fails++;
            $display("FAIL settle0_latency: got cycle %0d, expected %0d", t0, t + 2);
        end
        checks++;
        if (tm !== t + 4) begin
            fails++;
            $display("FAIL settle2_latency: got cycle %0d, expected %0d", tm, t + 4);
        end
        checks++;
        if (out_data0 !== 8'd0 || out_idx0 !== 4'd0) begin
            fails++;
            $display("FAIL settle0_first: got idx %0d data %0d, expected idx 0 data 0", out_idx0, out_data0);
        end
        drain(NEURONS, -1, 0, tf, tl);
    endtask

    task automatic test_basic();
        int t, e, tf, tl;
        logic [IN*WIDTH-1:0] xe;
        do_reset();
        out_ready = 1'b1;
        for (int n = 0; n < NEURONS; n++) zv[n] = n * 192;
        load_z(0);
        foreach (zv[n]) exp_q.push_back(n * 256 + int'({8'd0, 8'd2, 8'd3, 8'd5, 8'd6, 8'd8, 8'd9, 8'd11, 8'd12, 8'd14} >> (8 * (NEURONS - 1 - n)) & 8'hFF));
        send_frame(IN, IN - 1, 0, t, e);
        drain(NEURONS, -1, 0, tf, tl);
        checks++;
        if (tf !== t + 4) begin
            fails++;
            $display("FAIL basic_latency: got cycle %0d, expected %0d", tf, t + 4);
        end
        checks++;
        if (e !== 0) begin
            fails++;
            $display("FAIL basic_err: got %0d pulses, expected 0", e);
        end
        for (int i = 0; i < IN; i++) xe[i*WIDTH +: WIDTH] = WIDTH'(i);
        checks++;
        if (x_bus !== xe) begin
            fails++;
            $display("FAIL basic_xbus: got slot1 %0d slot127 %0d, expected 1 127", x_bus[15:8], x_bus[IN*WIDTH-1 -: 8]);
        end
    endtask

    task automatic test_round();
        int t, e, tf, tl;
        zv[0] = 63; zv[1] = 64; zv[2] = 'h7FFF80; zv[3] = 32703;
        for (int n = 4; n < NEURONS; n++) zv[n] = n * 1000;
        load_z(0);
        exp_q.push_back(0 * 256 + 0);
        exp_q.push_back(1 * 256 + 1);
        exp_q.push_back(2 * 256 + 255);
        exp_q.push_back(3 * 256 + 255);
        for (int n = 4; n < NEURONS; n++) exp_q.push_back(n * 256 + model(zv[n]));
        send_frame(IN, IN - 1, 7, t, e);
        drain(NEURONS, -1, 0, tf, tl);
    endtask

    task automatic test_back_to_back();
        int t, e, tf, tl, tf2, tl2, k;
        out_ready = 1'b0;
        for (int n = 0; n < NEURONS; n++) zv[n] = n * 2500 + 300;
        load_z(1);
        send_frame(IN, IN - 1, 3, t, e);
        k = 0;
        while (!out_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        for (int n = 0; n < NEURONS; n++) zv[n] = (NEURONS - n) * 3100 + 77;
        load_z(1);
        send_frame(IN, IN - 1, 40, t, e);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || busy !== 1'b1 || out_idx !== 4'd0 || out_data !== 8'(model(300))) begin
                fails++;
                $display("FAIL bp_wait: got rdy %b busy %b idx %0d data %0d, expected 0 1 0 %0d",
                         in_ready, busy, out_idx, out_data, model(300));
            end
        end
        drain(NEURONS, 3, 5, tf, tl);
        drain(NEURONS, -1, 0, tf2, tl2);
        checks++;
        if (tf2 !== tl + 2) begin
            fails++;
            $display("FAIL bp_capture: got cycle %0d, expected %0d", tf2, tl + 2);
        end
    endtask

    task automatic test_framing();
        int t, e, tf, tl, bad;
        out_ready = 1'b1;
        send_frame(51, 50, 0, t, e);
        checks++;
        if (e !== 1) begin
            fails++;
            $display("FAIL early_last_err: got %0d pulses, expected 1", e);
        end
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid || err || busy) bad++;
        end
        checks++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL early_last_quiet: got %0d active cycles, expected 0", bad);
        end
        for (int n = 0; n < NEURONS; n++) zv[n] = n * 777 + 11;
        load_z(1);
        send_frame(IN, IN - 1, 9, t, e);
        drain(NEURONS, -1, 0, tf, tl);
        checks++;
        if (e !== 0) begin
            fails++;
            $display("FAIL recover_err: got %0d pulses, expected 0", e);
        end
        for (int n = 0; n < NEURONS; n++) zv[n] = n * 4096 + 63;
        load_z(1);
        send_frame(IN, -1, 5, t, e);
        checks++;
        if (e !== 1) begin
            fails++;
            $display("FAIL missing_last_err: got %0d pulses, expected 1", e);
        end
        drain(NEURONS, -1, 0, tf, tl);
    endtask

    task automatic test_reset_mid();
        int t, e, tf, tl;
        for (int n = 0; n < NEURONS; n++) zv[n] = n * 999 + 1;
        load_z(1);
        send_frame(IN, IN - 1, 1, t, e);
        drain(4, -1, 0, tf, tl);
        checks++;
        if (out_valid !== 1'b1 || out_idx !== 4'd4) begin
            fails++;
            $display("FAIL pre_reset_idx: got vld %b idx %0d, expected 1 4", out_valid, out_idx);
        end
        exp_q.delete();
        do_reset();
        for (int n = 0; n < NEURONS; n++) zv[n] = n * 5000 + 64;
        load_z(1);
        send_frame(IN, IN - 1, 2, t, e);
        drain(NEURONS, -1, 0, tf, tl);
    endtask

    initial begin
        test_reset();
        test_settle0();
        test_basic();
        test_round();
        test_back_to_back();
        test_framing();
        test_reset_mid();
        checks++;
        if (exp_q.size() !== 0) begin
            fails++;
            $display("FAIL scoreboard_empty: got %0d pending, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
